// File: rtl/core_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : core_add_sub_pipe
// Purpose  : Two-stage floating-point add/subtract core. Stage 1 resolves the
//            effective operation, orders the operands by magnitude and aligns
//            the smaller mantissa. Stage 2 adds or subtracts the aligned
//            mantissas and produces an unnormalized result for a downstream
//            normalizer. Valid/ready handshakes on both sides with full
//            per-stage back-pressure.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, op_sub, a_sign/b_sign, a_te/b_te, a_mant/b_mant
//            out_valid/out_ready, out_sign, out_te, out_mant (carry at MSB),
//            out_zero, out_sticky
// Config   : STICKY_BIT_EN - when defined, out_sticky reports whether any
//            nonzero bit of the smaller operand was shifted out during
//            alignment; otherwise out_sticky is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module core_add_sub_pipe #(
    parameter int MANT_SIZE = 14,
    parameter int TE_SIZE   = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_sub,
    input  logic                     a_sign,
    input  logic                     b_sign,
    input  logic [TE_SIZE-1:0]       a_te,
    input  logic [TE_SIZE-1:0]       b_te,
    input  logic [MANT_SIZE-1:0]     a_mant,
    input  logic [MANT_SIZE-1:0]     b_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic [TE_SIZE-1:0]       out_te,
    output logic [2*MANT_SIZE:0]     out_mant,
    output logic                     out_zero,
    output logic                     out_sticky
);

    localparam int C_EXT_W = 2*MANT_SIZE + 1;

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic w_s1_ready, w_s2_ready, w_s1_load, w_s2_load;

    assign w_s2_ready = !s2_valid_q || out_ready;
    assign w_s1_ready = !s1_valid_q || w_s2_ready;
    assign w_s1_load  = in_valid && w_s1_ready;
    assign w_s2_load  = s1_valid_q && w_s2_ready;
    assign in_ready   = w_s1_ready;

    // ---------------- stage 1: order and align ----------------
    logic                     w_eff_b_sign, w_eff_sub, w_a_big, w_big_sign;
    logic [TE_SIZE-1:0]       w_big_te, w_small_te;
    logic [MANT_SIZE-1:0]     w_big_mant, w_small_mant;
    logic [TE_SIZE:0]         w_shift;
    logic                     w_shift_sat;
    logic [C_EXT_W-1:0]       w_big_ext, w_small_ext, w_small_shifted;

    always_comb begin
        w_eff_b_sign = b_sign ^ op_sub;
        w_eff_sub    = a_sign ^ w_eff_b_sign;
        // A wins full ties so equal operands subtract to a clean zero.
        w_a_big = ($signed(a_te) > $signed(b_te)) ||
                  ((a_te == b_te) && (a_mant >= b_mant));
        if (w_a_big) begin
            w_big_sign   = a_sign;
            w_big_te     = a_te;
            w_small_te   = b_te;
            w_big_mant   = a_mant;
            w_small_mant = b_mant;
        end else begin
            w_big_sign   = w_eff_b_sign;
            w_big_te     = b_te;
            w_small_te   = a_te;
            w_big_mant   = b_mant;
            w_small_mant = a_mant;
        end
        // Sign-extended difference is never negative after ordering.
        w_shift     = {w_big_te[TE_SIZE-1], w_big_te} - {w_small_te[TE_SIZE-1], w_small_te};
        w_shift_sat = (int'(w_shift) >= 2*MANT_SIZE);
        w_big_ext   = {1'b0, w_big_mant, {MANT_SIZE{1'b0}}};
        w_small_ext = {1'b0, w_small_mant, {MANT_SIZE{1'b0}}};
        if (w_shift_sat) begin
            w_small_shifted = '0;
        end else begin
            w_small_shifted = w_small_ext >> w_shift;
        end
    end

    logic                 s1_sign_q, s1_sign_d;
    logic                 s1_sub_q,  s1_sub_d;
    logic [TE_SIZE-1:0]   s1_te_q,   s1_te_d;
    logic [C_EXT_W-1:0]   s1_big_q,  s1_big_d;
    logic [C_EXT_W-1:0]   s1_small_q, s1_small_d;

    // ---------------- stage 2: add / subtract ----------------
    logic [C_EXT_W-1:0]   w_sum;
    logic                 s2_sign_q, s2_sign_d;
    logic                 s2_zero_q, s2_zero_d;
    logic [TE_SIZE-1:0]   s2_te_q,   s2_te_d;
    logic [C_EXT_W-1:0]   s2_mant_q, s2_mant_d;

    // big >= aligned small, so the difference never goes negative; the
    // extension's zero MSB absorbs the carry of an addition.
    assign w_sum = s1_sub_q ? (s1_big_q - s1_small_q) : (s1_big_q + s1_small_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_sub_d   = s1_sub_q;
        s1_te_d    = s1_te_q;
        s1_big_d   = s1_big_q;
        s1_small_d = s1_small_q;
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_te_d    = s2_te_q;
        s2_mant_d  = s2_mant_q;
        if (w_s1_ready) begin
            s1_valid_d = in_valid;
        end
        if (w_s1_load) begin
            s1_sign_d  = w_big_sign;
            s1_sub_d   = w_eff_sub;
            s1_te_d    = w_big_te;
            s1_big_d   = w_big_ext;
            s1_small_d = w_small_shifted;
        end
        if (w_s2_ready) begin
            s2_valid_d = s1_valid_q;
        end
        if (w_s2_load) begin
            s2_mant_d = w_sum;
            s2_te_d   = s1_te_q;
            s2_zero_d = (w_sum == '0);
            s2_sign_d = (w_sum == '0) ? 1'b0 : s1_sign_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_te_q    <= '0;
            s1_big_q   <= '0;
            s1_small_q <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_te_q    <= '0;
            s2_mant_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_te_q    <= s1_te_d;
            s1_big_q   <= s1_big_d;
            s1_small_q <= s1_small_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_te_q    <= s2_te_d;
            s2_mant_q  <= s2_mant_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = s2_sign_q;
    assign out_te    = s2_te_q;
    assign out_mant  = s2_mant_q;
    assign out_zero  = s2_zero_q;

`ifdef STICKY_BIT_EN
    // Shifted-out bits are those below position w_shift; when saturated the
    // whole small operand is lost.
    logic w_sticky;
    logic s1_sticky_q, s1_sticky_d;
    logic s2_sticky_q, s2_sticky_d;

    always_comb begin
        if (w_shift_sat) begin
            w_sticky = |w_small_ext;
        end else begin
            w_sticky = |(w_small_ext & ~({C_EXT_W{1'b1}} << w_shift));
        end
        s1_sticky_d = s1_sticky_q;
        s2_sticky_d = s2_sticky_q;
        if (w_s1_load) begin
            s1_sticky_d = w_sticky;
        end
        if (w_s2_load) begin
            s2_sticky_d = s1_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sticky_q <= 1'b0;
            s2_sticky_q <= 1'b0;
        end else begin
            s1_sticky_q <= s1_sticky_d;
            s2_sticky_q <= s2_sticky_d;
        end
    end

    assign out_sticky = s2_sticky_q;
`else
    assign out_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/core_add_sub_pipe.md
CORE_ADD_SUB_PIPE -- requirements
Module: core_add_sub_pipe

Interface
REQ-001 SHALL have parameter MANT_SIZE, default 14, mantissa width including hidden bit at MSB.
REQ-002 SHALL have parameter TE_SIZE, default 7, total-exponent width, two's complement.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port op_sub  input  1  1 = A-B, 0 = A+B.
REQ-008 SHALL have ports a_sign/b_sign  input  1  operand signs.
REQ-009 SHALL have ports a_te/b_te  input  TE_SIZE  operand total exponents.
REQ-010 SHALL have ports a_mant/b_mant  input  MANT_SIZE  operand mantissas, hidden bit set unless zero.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  normalizer accepts result.
REQ-013 SHALL have port out_sign  output  1  result sign.
REQ-014 SHALL have port out_te  output  TE_SIZE  exponent of larger-magnitude operand.
REQ-015 SHALL have port out_mant  output  2*MANT_SIZE+1  unnormalized result, carry bit at MSB; direct normalizer input.
REQ-016 SHALL have port out_zero  output  1  result magnitude exactly zero.
REQ-017 SHALL have port out_sticky  output  1  OR of alignment bits shifted out.

Function
REQ-018 SHALL be a 2-stage pipeline; latency exactly 2 cycles from accepted input to out_valid when unstalled; throughput 1/cycle.
REQ-019 Stage 1 SHALL compute eff_b_sign = b_sign^op_sub and eff_sub = a_sign^eff_b_sign, and swap operands so "big" has larger te, ties broken by larger mant (A wins full ties).
REQ-020 Stage 1 SHALL extend each mant to 2*MANT_SIZE+1 bits as {1'b0, mant, MANT_SIZE zeros}, then right-shift small by d = big_te - small_te.
REQ-021 When d >= 2*MANT_SIZE, shifted small SHALL be all zeros.
REQ-022 Stage 2 SHALL output big+small if eff_sub=0, else big-small (never negative).
REQ-023 out_sign SHALL be big's effective sign; out_te SHALL be big_te; carry not folded into te (normalizer handles it).
REQ-024 Zero result SHALL give out_mant=0, out_zero=1, out_sign=0.
REQ-025 Each stage SHALL hold its register when its valid is set and the next stage is not accepting; stage advances iff next is empty or advancing.
REQ-026 in_ready SHALL be 1 when stage 1 empty or stage 1 advancing; combinational from out_ready allowed, no combinational in_valid->out_valid path.
REQ-027 Transfer SHALL occur only on valid&&ready; held out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 Results SHALL emerge in input order; no drop or duplication under any stall pattern.
REQ-029 Simultaneous output handshake and input handshake with both stages full SHALL accept the input with no bubble.

Reset
REQ-030 rst_n low SHALL asynchronously clear both stage valids; out_valid=0, out_mant=0, out_te=0, out_sign=0, out_zero=0, out_sticky=0.
REQ-031 in_ready SHALL be 1 one cycle after rst_n deasserts; reset mid-operation SHALL discard in-flight results.

Configuration
REQ-032 With STICKY_BIT_EN defined, out_sticky SHALL be the OR of all nonzero bits shifted out of small during alignment, pipelined with its result.
REQ-033 Without STICKY_BIT_EN, out_sticky SHALL be constant 0 and no sticky logic synthesized.

Verification
REQ-034 a=+1.0(te 0, mant 0x2000), b=+1.0, op_sub=0 -> after 2 cycles out_mant=0x1000_0000, out_te=0, out_sign=0, out_zero=0.
REQ-035 Same operands, op_sub=1 -> out_mant=0, out_zero=1, out_sign=0.
REQ-036 a te=3 mant 0x2000, b te=0 mant 0x2000, add -> out_mant=0x0900_0000, out_te=3; swapped operands give identical result.
REQ-037 a te=40, b te=0 mant 0x2001, add, macro on -> out_mant=0x0800_0000, out_te=40, out_sticky=1; macro off -> out_sticky=0.
REQ-038 Stream 5 inputs back-to-back, out_ready=0 cycles 2-4 -> in_ready falls after 2 held results, all 5 results correct and in order, held outputs stable.
REQ-039 rst_n pulsed low with both stages full -> out_valid=0 immediately, no stale result after release.
